// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size codes
// and the default memory latency.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MEM_LAT_DEFAULT = 2;

    // Reserved size or an address not naturally aligned to the access size.
    function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane handling for the load/store unit: extends loaded sub-words and
// merges sub-word store data into a memory word (little-endian lanes).
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_word >> {byte_off, 3'b000};
        case (size)
            SZ_BYTE: load_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (size)
            SZ_BYTE: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
            SZ_HALF: merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-wide memory port, sub-word
// stores done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] aluResult,
    output logic [31:0] writeDataMem,
    input  logic [31:0] readData
);

    localparam logic [3:0] CNT_RELOAD = 4'(MEM_LAT - 1);

    lsu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wmem_q, wmem_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;

    lsu_lane_align u_align (
        .byte_off    (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .mem_word    (rdata_q),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wmem_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wmem_q  <= wmem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wmem_d  = wmem_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmem_d  = req_wdata;
                    rdata_d = '0;
                    err_d   = lsu_bad_access(req_size, req_addr[1:0]);
                    cnt_d   = CNT_RELOAD;
                    if (err_d) begin
                        state_d = S_RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = readData;
                    state_d = write_q ? S_MERGE : S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_MERGE: begin
                wmem_d  = merged_word;
                cnt_d   = CNT_RELOAD;
                state_d = S_WR;
            end
            S_WR: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address stays driven through the whole operation so it is stable under
    // every strobe; write data is only presented while the write strobe is up.
    always_comb begin
        req_ready    = (state_q == S_IDLE);
        MemRead      = (state_q == S_RD);
        MemWrite     = (state_q == S_WR);
        resp_valid   = (state_q == S_RESP);
        resp_error   = (state_q == S_RESP) && err_q;
        aluResult    = (state_q == S_IDLE) ? '0 : {2'b00, addr_q[31:2]};
        writeDataMem = (state_q == S_WR) ? wmem_q : '0;
        resp_rdata   = (state_q == S_RESP && !err_q && !write_q) ? load_data : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised self-checking bench for load_store_unit against a byte-array
// reference memory and the latency/strobe rules of the unit.
module tb_load_store_unit;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] aluResult;
    logic [31:0] writeDataMem;
    logic [31:0] readData;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .aluResult    (aluResult),
        .writeDataMem (writeDataMem),
        .readData     (readData)
    );

    // Environment memory: 16 words, aliased on the low address bits.
    logic [31:0] env_mem [16];
    assign readData = env_mem[aluResult[3:0]];
    always @(posedge clk) if (MemWrite) env_mem[aluResult[3:0]] <= writeDataMem;

    // Reference model: plain byte array with the same aliasing.
    logic [7:0] ref_mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'd3) return 1'b1;
        return (addr % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(addr + i) % 64]) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) v = v + (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(addr + i) % 64] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int base;
        base = int'(addr % 64) & ~3;
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    // Issues one request from an idle cycle and checks it to completion.
    // Returns one cycle after the response, with the unit idle again.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd_out, output int lat_out);
        logic        exp_err;
        logic [31:0] exp_rd, exp_word;
        int exp_lat, exp_rdc, exp_wrc;
        int n_rd = 0, n_wr = 0, overlap = 0, alu_bad = 0, wdm_bad = 0;
        int cyc;
        logic done = 1'b0;

        exp_err  = ref_err(sz, addr);
        exp_rd   = (!exp_err && !wr) ? ref_load(sz, uns, addr) : 32'h0;
        exp_word = 32'h0;
        if (!exp_err && wr) begin
            ref_store(sz, addr, wd);
            exp_word = ref_word(addr);
        end
        exp_lat = exp_err ? 1 : (wr && sz != 2'd2) ? 2 * LAT + 2 : LAT + 1;
        exp_rdc = (exp_err || (wr && sz == 2'd2)) ? 0 : LAT;
        exp_wrc = (!exp_err && wr) ? LAT : 0;

        check_eq("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        cyc = 1;
        while (!done && cyc <= 40) begin
            if (MemRead) n_rd++;
            if (MemWrite) begin
                n_wr++;
                if (writeDataMem !== exp_word) wdm_bad++;
            end
            if (MemRead && MemWrite) overlap++;
            if ((MemRead || MemWrite) && aluResult !== {2'b00, addr[31:2]}) alu_bad++;
            if (resp_valid) done = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq("resp_seen", 32'(done), 32'd1);
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("resp_error", 32'(resp_error), 32'(exp_err));
        check_eq("resp_rdata", resp_rdata, exp_rd);
        check_eq("memread_cycles", 32'(n_rd), 32'(exp_rdc));
        check_eq("memwrite_cycles", 32'(n_wr), 32'(exp_wrc));
        check_eq("strobe_overlap", 32'(overlap), 32'd0);
        check_eq("alu_addr_bad", 32'(alu_bad), 32'd0);
        check_eq("wdata_bad", 32'(wdm_bad), 32'd0);
        rd_out  = resp_rdata;
        lat_out = cyc;

        @(posedge clk); #1;
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        check_eq("idle_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("idle_alu", aluResult, 32'h0);
        check_eq("idle_wdm", writeDataMem, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, a_exp, b_exp, addr;
        logic        wr, uns;
        logic [1:0]  sz;
        int          l, cyc, pulses;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int w = 0; w < 16; w++) begin
            env_mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4 * w + b] = 8'((env_mem[w] >> (8 * b)) & 32'hFF);
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_error", 32'(resp_error), 32'd0);
        check_eq("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_alu", aluResult, 32'h0);
        check_eq("rst_wdm", writeDataMem, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed sequence around address 0x10.
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, l);
        check_eq("d_wst_lat", 32'(l), 32'd3);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, l);
        check_eq("d_wld_data", r, 32'hDEADBEEF);
        check_eq("d_wld_lat", 32'(l), 32'd3);
        run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, r, l);
        check_eq("d_sbyte", r, 32'hFFFFFFDE);
        run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, r, l);
        check_eq("d_uhalf", r, 32'h0000DEAD);
        run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, r, l);
        check_eq("d_bst_lat", 32'(l), 32'd6);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, l);
        check_eq("d_merged", r, 32'hDEAD55EF);
        run_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, r, l);
        check_eq("d_mis_lat", 32'(l), 32'd1);
        run_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, r, l);
        check_eq("d_rsv_lat", 32'(l), 32'd1);

        // Reset during the second read cycle of a load.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_rd2", 32'(MemRead), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_mid_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            if (resp_valid) pulses++;
            @(posedge clk); #1;
        end
        check_eq("rst_mid_no_resp", 32'(pulses), 32'd0);

        // Back-to-back loads with req_valid held high.
        a_exp = ref_load(2'd2, 1'b0, 32'h10);
        b_exp = ref_load(2'd2, 1'b0, 32'h14);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h14;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_eq("b2b_a_lat", 32'(cyc), 32'(LAT + 1));
        check_eq("b2b_a_data", resp_rdata, a_exp);
        @(posedge clk); #1;
        check_eq("b2b_ready_after_resp", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_eq("b2b_b_lat", 32'(cyc), 32'(LAT + 1));
        check_eq("b2b_b_data", resp_rdata, b_exp);
        @(posedge clk); #1;

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            wr   = 1'($urandom);
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            run_req(wr, sz, uns, addr, $urandom, r, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles a memory strobe is held before data is sampled or the write is considered done; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  unit accepts a request this cycle; handshake when req_valid and req_ready are both high.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle pulse: request complete.
REQ-012 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 resp_error  output  1  valid with resp_valid: misaligned address or reserved size.
REQ-014 MemRead  output  1  read strobe to data memory.
REQ-015 MemWrite  output  1  write strobe to data memory.
REQ-016 aluResult  output  32  word address to memory = {2'b00, req_addr[31:2]}.
REQ-017 writeDataMem  output  32  full word written to memory.
REQ-018 readData  input  32  word returned by memory.

Function
REQ-019 FSM states IDLE, RD, MERGE, WR, RESP; req_ready SHALL be high only in IDLE.
REQ-020 Request fields SHALL be captured at handshake; later input changes have no effect.
REQ-021 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or size 11: IDLE->RESP, resp_error=1, no strobe asserted.
REQ-022 Load: IDLE->RD; MemRead held MEM_LAT cycles; readData sampled in the last RD cycle; RD->RESP.
REQ-023 Word store: IDLE->WR; writeDataMem=req_wdata; MemWrite held MEM_LAT cycles; WR->RESP.
REQ-024 Byte/halfword store (read-modify-write): IDLE->RD->MERGE->WR->RESP; MERGE replaces only the addressed lanes of the sampled word with req_wdata's low byte/halfword.
REQ-025 Lane order little-endian: addr[1:0]=0 selects bits 7:0, addr[1]=1 selects halfword bits 31:16.
REQ-026 MemRead and MemWrite SHALL never be high together; MERGE drives both low for exactly one cycle.
REQ-027 aluResult and writeDataMem SHALL be stable whenever a strobe is high; 0 in IDLE.
REQ-028 RESP lasts one cycle, asserts resp_valid, then returns to IDLE; no backpressure on the response.
REQ-029 Latency, handshake cycle = 0: load/word store resp_valid at cycle MEM_LAT+1; sub-word store at 2*MEM_LAT+2; error at cycle 1.
REQ-030 A new request may be accepted in the cycle after RESP; back-to-back throughput is one request per latency+1 cycles.
REQ-031 Load extension: byte/halfword extended per req_unsigned; word passed unchanged.

Reset
REQ-032 On reset: state IDLE; req_ready=1; resp_valid, resp_error, MemRead, MemWrite = 0; resp_rdata, aluResult, writeDataMem = 0.
REQ-033 Reset mid-operation aborts at the next edge: strobes drop, no response is produced, and the in-flight request is discarded.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the MEM_LAT default.
REQ-035 Lane merge and load extension SHALL live in a combinational sub-module, lsu_lane_align.
REQ-036 The strobe-hold counter SHALL be 4 bits wide and reload on every RD/WR entry.

Verification
REQ-037 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> aluResult=0x4; MemWrite high 2 cycles; load resp_rdata=0xDEADBEEF at cycle 3.
REQ-038 After REQ-037, signed byte load 0x13 -> 0xFFFFFFDE; unsigned halfword load 0x12 -> 0x0000DEAD.
REQ-039 Byte store 0x55 to 0x11 after REQ-037 -> RD, MERGE, WR; writeDataMem=0xDEAD55EF; resp_valid at cycle 6; MemRead and MemWrite never overlap.
REQ-040 Halfword load at 0x21, and size 11 at 0x20 -> resp_error=1 at cycle 1; MemRead and MemWrite stay 0.
REQ-041 Reset asserted during the second RD cycle of a load -> strobes 0 and req_ready=1 next cycle; no resp_valid.
REQ-042 Back-to-back loads with req_valid held high -> second handshake in the cycle after the first RESP; each response matches its address.
